sram_responder: RTL
===================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Param DEPTH_LOG2, default 10, log2 of memory depth in 32-bit words.
REQ-002 Param BASE, default 32'h1c00_0000, byte base address of the memory window; aligned to 4*2^DEPTH_LOG2.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_sram_we  in  1  instruction-port write enable; must be 0, treated as protocol error.
REQ-006 inst_sram_addr  in  32  instruction-port byte address.
REQ-007 inst_sram_wdata  in  32  ignored.
REQ-008 inst_sram_rdata  out  32  instruction read data.
REQ-009 data_sram_we  in  1  data-port word write enable.
REQ-010 data_sram_addr  in  32  data-port byte address.
REQ-011 data_sram_wdata  in  32  data-port write data.
REQ-012 data_sram_rdata  out  32  data-port read data.
REQ-013 load_valid  in  1  preload write request.
REQ-014 load_addr  in  DEPTH_LOG2  preload word index.
REQ-015 load_data  in  32  preload data.
REQ-016 load_ready  out  1  preload accepted when load_valid & load_ready.
REQ-017 init_done  out  1  memory cleared, ports live.
REQ-018 err  out  3  sticky: [0] inst out-of-range, [1] data out-of-range, [2] inst_sram_we seen.
REQ-019 err_addr  out  32  byte address of first out-of-range access.

Function
REQ-020 Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored, no alignment error.
REQ-021 In range iff addr[31:DEPTH_LOG2+2] == BASE[31:DEPTH_LOG2+2].
REQ-022 FSM states CLEAR, RUN; reset -> CLEAR with clear counter 0.
REQ-023 CLEAR: each cycle write 32'h0 to word[counter], counter+1; at counter == 2^DEPTH_LOG2-1 the write occurs and next state is RUN.
REQ-024 CLEAR lasts exactly 2^DEPTH_LOG2 cycles; init_done = 1 iff state RUN (registered).
REQ-025 During CLEAR: both rdata outputs 0, CPU writes and loads dropped, err not updated, load_ready 0.
REQ-026 RUN: read latency 1 cycle; rdata in cycle N+1 = word at address sampled in cycle N.
REQ-027 Out-of-range read returns 32'h0 next cycle; out-of-range write dropped.
REQ-028 Data write in range: word[index] <= data_sram_wdata at the edge.
REQ-029 Read-first: same-cycle read (either port) of the word being written returns old value; following cycle returns new value.
REQ-030 load_ready = RUN & ~data_sram_we; CPU data write always wins over preload, loader stalls.
REQ-031 Accepted preload writes load_data to word[load_addr]; load_addr always in range.
REQ-032 err bits set in RUN on the offending cycle, held until reset; err_addr captured only when err[1:0] transitions from 00, inst port captured when both ports offend same cycle.
REQ-033 err[2] set whenever inst_sram_we = 1 in RUN; instruction write never performed.
REQ-034 Data-port reads occur every cycle regardless of data_sram_we (CPU has no read strobe).

Reset
REQ-035 On reset: inst_sram_rdata = 0, data_sram_rdata = 0, init_done = 0, load_ready = 0, err = 0, err_addr = 0, state CLEAR, counter 0.
REQ-036 Reset mid-CLEAR restarts counter at 0; reset in RUN re-clears entire memory.
REQ-037 Memory contents not otherwise reset; only CLEAR zeroes them.

Verification (DEPTH_LOG2 = 4, BASE = 32'h1c00_0000)
REQ-038 Release reset -> init_done rises after exactly 16 cycles; all 16 words read 0.
REQ-039 Preload word 0 = 32'h02800413 via load handshake, then inst_sram_addr = 32'h1c00_0000 -> inst_sram_rdata = 32'h02800413 one cycle later.
REQ-040 Data write 32'hdeadbeef to 32'h1c00_0008 with simultaneous inst read of same address -> inst rdata old value (0) next cycle, new value the cycle after.
REQ-041 load_valid held with data_sram_we = 1 -> load_ready 0, preload not written; accepted first cycle data_sram_we = 0.
REQ-042 data read 32'h1bff_fffc -> data_sram_rdata 0, err = 3'b010, err_addr = 32'h1bff_fffc; later inst_sram_we pulse -> err = 3'b110, err_addr unchanged.
REQ-043 Assert reset at clear count 7 -> init_done stays 0 a further 16 cycles after release.

Source files
------------

// File: rtl/sram_responder_if.sv
// Bus bundle for sram_responder: instruction port, data port, preload channel and status.
// The CPU/loader side uses the master modport, the memory model uses slave.
interface sram_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic                  inst_sram_we;
  logic [31:0]           inst_sram_addr;
  logic [31:0]           inst_sram_wdata;
  logic [31:0]           inst_sram_rdata;
  logic                  data_sram_we;
  logic [31:0]           data_sram_addr;
  logic [31:0]           data_sram_wdata;
  logic [31:0]           data_sram_rdata;
  logic                  load_valid;
  logic [DEPTH_LOG2-1:0] load_addr;
  logic [31:0]           load_data;
  logic                  load_ready;
  logic                  init_done;
  logic [2:0]            err;
  logic [31:0]           err_addr;

  modport slave (
    input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  data_sram_we, data_sram_addr, data_sram_wdata,
    input  load_valid, load_addr, load_data,
    output inst_sram_rdata, data_sram_rdata, load_ready,
    output init_done, err, err_addr
  );

  modport master (
    output inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output data_sram_we, data_sram_addr, data_sram_wdata,
    output load_valid, load_addr, load_data,
    input  inst_sram_rdata, data_sram_rdata, load_ready,
    input  init_done, err, err_addr
  );
endinterface

// File: rtl/sram_responder.sv
// Dual-port (instruction read / data read-write) SRAM model with preload channel,
// self-clearing after reset and sticky error capture for out-of-window accesses.
//
// state | meaning
// CLEAR | zeroing one word per cycle, ports dead, errors frozen
// RUN   | ports live, 1-cycle read latency, read-first on same-word write
module sram_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE       = 32'h1c00_0000
) (
  input  logic            clk,
  input  logic            reset,
  sram_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] inst_idx;
  logic [DEPTH_LOG2-1:0] data_idx;
  logic                  inst_hit;
  logic                  data_hit;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;
  logic                  load_ready;
  logic                  unused_bits;

  assign inst_idx = bus.inst_sram_addr[DEPTH_LOG2+1:2];
  assign data_idx = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign inst_hit = (bus.inst_sram_addr[31:DEPTH_LOG2+2] == BASE[31:DEPTH_LOG2+2]);
  assign data_hit = (bus.data_sram_addr[31:DEPTH_LOG2+2] == BASE[31:DEPTH_LOG2+2]);

  // Byte lanes and instruction write data have no effect on a word-wide model.
  assign unused_bits = ^{bus.inst_sram_wdata, bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};

  assign load_ready     = (state == RUN) && !bus.data_sram_we;
  assign bus.load_ready = load_ready;
  assign bus.init_done  = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    case (state)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        if (clr_cnt == {DEPTH_LOG2{1'b1}}) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // CPU data writes take priority; the loader simply stalls on load_ready.
        if (bus.data_sram_we && data_hit) begin
          mem_we    = 1'b1;
          mem_waddr = data_idx;
          mem_wdata = bus.data_sram_wdata;
        end else if (bus.load_valid && load_ready) begin
          mem_we    = 1'b1;
          mem_waddr = bus.load_addr;
          mem_wdata = bus.load_data;
        end
      end
      default: state_next = CLEAR;
    endcase
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Reads use the pre-edge array contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.inst_sram_rdata <= '0;
      bus.data_sram_rdata <= '0;
    end else if (state == RUN) begin
      bus.inst_sram_rdata <= inst_hit ? mem[inst_idx] : 32'h0;
      bus.data_sram_rdata <= data_hit ? mem[data_idx] : 32'h0;
    end else begin
      bus.inst_sram_rdata <= '0;
      bus.data_sram_rdata <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.err      <= '0;
      bus.err_addr <= '0;
    end else if (state == RUN) begin
      bus.err <= bus.err | {bus.inst_sram_we, !data_hit, !inst_hit};
      if ((bus.err[1:0] == 2'b00) && (!inst_hit || !data_hit)) begin
        bus.err_addr <= !inst_hit ? bus.inst_sram_addr : bus.data_sram_addr;
      end
    end
  end
endmodule
